// File: rtl/lnet_input_packer.sv
// LogicNets input packer: quantizes raw signed features to 2-bit codes against
// per-feature thresholds and packs a sample into one vector. LNET_PACKER_SKID_EN adds a second output buffer.
module lnet_feat_quant #(
  parameter int FEAT_W = 16,
  parameter int A_W    = 5,
  parameter int BASE   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [A_W-1:0]           i_addr,
  input  logic signed [FEAT_W-1:0] i_wdata,
  input  logic signed [FEAT_W-1:0] i_x,
  output logic [1:0]               o_code
);
  logic signed [FEAT_W-1:0] r_thr [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) r_thr[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (i_we && i_addr == A_W'(BASE + k)) r_thr[k] <= i_wdata;
    end
  end

  assign o_code = {1'b0, i_x >= r_thr[0]} + {1'b0, i_x >= r_thr[1]} + {1'b0, i_x >= r_thr[2]};
endmodule

module lnet_input_packer #(
  parameter int FEAT_W   = 16,
  parameter int NUM_FEAT = 8,
  parameter int CODE_W   = 2,
  localparam int A_W     = $clog2(NUM_FEAT * 3)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [FEAT_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NUM_FEAT*CODE_W-1:0] m_data,
  input  logic                       thr_we,
  input  logic [A_W-1:0]             thr_addr,
  input  logic [FEAT_W-1:0]          thr_data,
  output logic                       err_frame,
  input  logic                       err_clr
);
  localparam int IDX_W = $clog2(NUM_FEAT);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FEAT - 1);

  logic [NUM_FEAT-1:0][CODE_W-1:0] w_codes, r_asm, w_asm_nxt;
  logic [IDX_W-1:0] r_idx;
  logic r_err, w_acc, w_is_last, w_err, w_done;

  // Every lane quantizes the current beat; only the lane at r_idx is kept.
  for (genvar g = 0; g < NUM_FEAT; g++) begin : g_lane
    lnet_feat_quant #(.FEAT_W(FEAT_W), .A_W(A_W), .BASE(g * 3)) u_quant (
      .clk(clk), .rst_n(rst_n), .i_we(thr_we), .i_addr(thr_addr),
      .i_wdata(thr_data), .i_x(s_data), .o_code(w_codes[g])
    );
  end

  assign w_acc     = s_valid && s_ready;
  assign w_is_last = (r_idx == LAST);
  assign w_err     = w_acc && (s_last != w_is_last);
  assign w_done    = w_acc && s_last && w_is_last;
  assign err_frame = r_err;

  always_comb begin
    w_asm_nxt        = r_asm;
    w_asm_nxt[r_idx] = w_codes[r_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_acc) begin
        r_asm <= w_asm_nxt;
        r_idx <= (w_done || w_err) ? '0 : r_idx + 1'b1;
      end
      if (w_err)        r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

`ifdef LNET_PACKER_SKID_EN
  // Two-entry output FIFO; the head entry stays put while the tail is refilled.
  logic [NUM_FEAT*CODE_W-1:0] r_buf0, r_buf1;
  logic       r_rd, r_wr, w_pop;
  logic [1:0] r_cnt;

  assign w_pop   = m_valid && m_ready;
  assign m_valid = (r_cnt != 2'd0);
  assign m_data  = r_rd ? r_buf1 : r_buf0;
  assign s_ready = !(r_cnt == 2'd2 && w_is_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_done) begin
        if (r_wr) r_buf1 <= w_asm_nxt;
        else      r_buf0 <= w_asm_nxt;
        r_wr <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_done, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
`else
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t r_state, w_state_nxt;
  logic [NUM_FEAT*CODE_W-1:0] r_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_done) r_out <= w_asm_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    case (r_state)
      COLLECT: begin
        s_ready = 1'b1;
        if (w_done) w_state_nxt = HOLD;
      end
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  assign m_data = r_out;
`endif
endmodule

// File: tb/tb_lnet_input_packer.sv
// Self-checking bench for lnet_input_packer against a threshold/quantize model.
module tb_lnet_input_packer;
  localparam int NF = 8;
  typedef int samp_t [NF];

  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 0, s_ready, s_last = 0, m_valid, m_ready = 0;
  logic thr_we = 0, err_frame, err_clr = 0;
  logic [15:0] s_data = '0, thr_data = '0, m_data;
  logic [4:0]  thr_addr = '0;

  int n_cmp = 0, n_err = 0;
  int ref_thr [NF*3];

  lnet_input_packer dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .thr_we(thr_we), .thr_addr(thr_addr), .thr_data(thr_data),
    .err_frame(err_frame), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_pack(input samp_t x);
    logic [15:0] v = '0;
    for (int i = 0; i < NF; i++) begin
      int c = 0;
      for (int k = 0; k < 3; k++) if (x[i] >= ref_thr[i*3+k]) c++;
      v[2*i +: 2] = 2'(c);
    end
    return v;
  endfunction

  function automatic samp_t rnd_samp(input int lim);
    samp_t s;
    for (int i = 0; i < NF; i++) s[i] = $urandom_range(0, 2*lim) - lim;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic beat(input int x, input logic last);
    int n = 0;
    s_valid = 1; s_data = 16'(x); s_last = last;
    while (s_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    if (n == 100) begin n_cmp++; n_err++; $display("FAIL beat_timeout: s_ready=%b required 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic wr_thr(input int a, input int d);
    thr_we = 1; thr_addr = 5'(a); thr_data = 16'(d);
    @(posedge clk); #1;
    thr_we = 0;
    if (a < NF*3) ref_thr[a] = d;
  endtask

  task automatic send_sample(input samp_t x, output logic [15:0] exp);
    exp = ref_pack(x);
    for (int i = 0; i < NF; i++) beat(x[i], i == NF-1);
  endtask

  task automatic get_vec(input logic [15:0] exp, input string nm);
    int n = 0;
    while (m_valid !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if (m_valid !== 1'b1) begin
      n_err++; $display("FAIL %s: m_valid=%b required 1 (timeout)", nm, m_valid);
    end else if (m_data !== exp) begin
      n_err++; $display("FAIL %s: m_data=%h required %h", nm, m_data, exp);
    end
    m_ready = 1; @(posedge clk); #1; m_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; #2;
    for (int i = 0; i < NF*3; i++) ref_thr[i] = 0;
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NF*3; i++) ref_thr[i] = 0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1;
    chk("rst_s_ready", 16'(s_ready), 16'd1);
    chk("rst_m_valid", 16'(m_valid), 16'd0);
    chk("rst_m_data", m_data, 16'd0);
    chk("rst_err_frame", 16'(err_frame), 16'd0);
  endtask

  task automatic test_defaults();
    samp_t x = '{5, -1, 0, -7, 100, -100, 1, -2};
    for (int i = 0; i < NF-1; i++) beat(x[i], 0);
    chk("dflt_no_early_valid", 16'(m_valid), 16'd0);
    beat(x[NF-1], 1);
    chk("dflt_latency", 16'(m_valid), 16'd1);
    chk("dflt_const", m_data, 16'b00_11_00_11_00_11_00_11);
    get_vec(ref_pack(x), "dflt_model");
  endtask

  task automatic test_thresholds();
    int ins [4] = '{-20, -10, 5, 10};
    logic [15:0] exp;
    wr_thr(0, -10); wr_thr(1, 0); wr_thr(2, 10);
    for (int j = 0; j < 4; j++) begin
      samp_t x = rnd_samp(50);
      x[0] = ins[j];
      send_sample(x, exp);
      chk("thr_code_f0", 16'(m_data[1:0]), 16'(j));
      get_vec(exp, "thr_model");
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    for (int j = 0; j < 6; j++) begin
      wr_thr($urandom_range(0, 31), $urandom_range(0, 400) - 200);
      wr_thr($urandom_range(0, 31), $urandom_range(0, 400) - 200);
      send_sample(rnd_samp(300), exp);
      get_vec(exp, "rand_model");
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp1, exp2;
    samp_t x2 = rnd_samp(300);
    exp2 = ref_pack(x2);
    send_sample(rnd_samp(300), exp1);
    for (int c = 0; c < 20; c++) begin
`ifdef LNET_PACKER_SKID_EN
      if (c < NF) begin
        chk("bp_skid_s_ready", 16'(s_ready), 16'd1);
        s_valid = 1; s_data = 16'(x2[c]); s_last = (c == NF-1);
      end else begin
        s_valid = 0; s_last = 0;
      end
`else
      chk("bp_s_ready_low", 16'(s_ready), 16'd0);
`endif
      @(posedge clk); #1;
      chk("bp_m_valid_held", 16'(m_valid), 16'd1);
      chk("bp_m_data_stable", m_data, exp1);
    end
    s_valid = 0; s_last = 0;
    get_vec(exp1, "bp_first");
`ifdef LNET_PACKER_SKID_EN
    get_vec(exp2, "bp_second");
`else
    chk("bp_ready_back", 16'(s_ready), 16'd1);
`endif
  endtask

  task automatic test_frame_err();
    logic [15:0] exp;
    samp_t x = rnd_samp(300);
    beat(x[0], 0); beat(x[1], 0); beat(x[2], 1);
    chk("ferr_set_early_last", 16'(err_frame), 16'd1);
    repeat (3) @(posedge clk); #1;
    chk("ferr_no_vector", 16'(m_valid), 16'd0);
    send_sample(rnd_samp(300), exp);
    get_vec(exp, "ferr_recover");
    chk("ferr_sticky", 16'(err_frame), 16'd1);
    err_clr = 1; @(posedge clk); #1; err_clr = 0;
    chk("ferr_clear", 16'(err_frame), 16'd0);
    for (int i = 0; i < NF-1; i++) beat(x[i], 0);
    err_clr = 1; beat(x[NF-1], 0); err_clr = 0;
    chk("ferr_set_wins", 16'(err_frame), 16'd1);
    chk("ferr_missing_last_no_vec", 16'(m_valid), 16'd0);
    err_clr = 1; @(posedge clk); #1; err_clr = 0;
    chk("ferr_clear2", 16'(err_frame), 16'd0);
    send_sample(rnd_samp(300), exp);
    get_vec(exp, "ferr_recover2");
  endtask

  task automatic test_thr_race();
    logic [15:0] exp;
    samp_t x = rnd_samp(300);
    x[2] = 50;
    wr_thr(6, 100); wr_thr(7, 100); wr_thr(8, 100);
    exp = ref_pack(x);
    beat(x[0], 0); beat(x[1], 0);
    chk("race_ready", 16'(s_ready), 16'd1);
    s_valid = 1; s_data = 16'(x[2]); s_last = 0;
    thr_we = 1; thr_addr = 5'd6; thr_data = 16'd0;
    @(posedge clk); #1;
    s_valid = 0; thr_we = 0; ref_thr[6] = 0;
    for (int i = 3; i < NF; i++) beat(x[i], i == NF-1);
    chk("race_old_thr", 16'(m_data[5:4]), 16'd0);
    get_vec(exp, "race_first");
    send_sample(x, exp);
    chk("race_new_thr", 16'(m_data[5:4]), 16'd1);
    get_vec(exp, "race_second");
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    samp_t x = rnd_samp(300);
    for (int i = 0; i < 4; i++) beat(x[i], 0);
    do_reset();
    chk("rmid_m_valid", 16'(m_valid), 16'd0);
    send_sample(rnd_samp(300), exp);
    get_vec(exp, "rmid_fresh");
    send_sample(rnd_samp(300), exp);
    rst_n = 0; #2;
    chk("rhold_m_valid", 16'(m_valid), 16'd0);
    chk("rhold_m_data", m_data, 16'd0);
    for (int i = 0; i < NF*3; i++) ref_thr[i] = 0;
    @(posedge clk); #1; rst_n = 1;
    send_sample(rnd_samp(300), exp);
    get_vec(exp, "rhold_fresh");
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_thresholds();
    test_random();
    test_backpressure();
    test_frame_err();
    test_thr_race();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
